// File: rtl/sdp_ram_arbiter.sv
// ---------------------------------------------------------------------------
// sdp_ram_arbiter
//
// Two-client front end for a simple dual-port RAM running in one clock
// domain. The RAM write port and read port are each shared between client 0
// and client 1 by an independent round-robin arbiter. The winning command is
// registered onto the RAM pins. Every issued read is tagged with its owner,
// and the returned data is steered back to the client that asked for it.
//
// Parameters
//   DATA_WIDTH       data width, a multiple of 8
//   ADDR_WIDTH       word address width
//   IS_OUT_LATENCY   "false" -> RAM read latency 1, "true" -> 2; must match
//                    the RAM instance
//   BYTE_VALID_WIDTH derived, DATA_WIDTH/8
//
// Ports (cN = c0 and c1)
//   clk, rst_n               clock, asynchronous active-low reset
//   cN_wr_req / cN_wr_gnt    write handshake, accepted on req && gnt
//   cN_wr_addr/_data/_byte_valid  write payload, held until granted
//   cN_rd_req / cN_rd_gnt    read handshake, same rule as writes
//   cN_rd_addr               read address
//   cN_rd_data               shared copy of ram_rd_data
//   cN_rd_data_valid         one-cycle pulse when returned data is ours
//   ram_wr_*                 registered RAM write port
//   ram_rd_en, ram_rd_addr   registered RAM read port
//   ram_rd_data, ram_rd_data_valid  RAM read return
// ---------------------------------------------------------------------------
module sdp_ram_arbiter #(
  parameter int    DATA_WIDTH       = 32,
  parameter int    ADDR_WIDTH       = 5,
  parameter string IS_OUT_LATENCY   = "false",
  localparam int   BYTE_VALID_WIDTH = DATA_WIDTH / 8
) (
  input  logic                        clk,
  input  logic                        rst_n,

  input  logic                        c0_wr_req,
  output logic                        c0_wr_gnt,
  input  logic [ADDR_WIDTH-1:0]       c0_wr_addr,
  input  logic [DATA_WIDTH-1:0]       c0_wr_data,
  input  logic [BYTE_VALID_WIDTH-1:0] c0_wr_byte_valid,
  input  logic                        c0_rd_req,
  output logic                        c0_rd_gnt,
  input  logic [ADDR_WIDTH-1:0]       c0_rd_addr,
  output logic [DATA_WIDTH-1:0]       c0_rd_data,
  output logic                        c0_rd_data_valid,

  input  logic                        c1_wr_req,
  output logic                        c1_wr_gnt,
  input  logic [ADDR_WIDTH-1:0]       c1_wr_addr,
  input  logic [DATA_WIDTH-1:0]       c1_wr_data,
  input  logic [BYTE_VALID_WIDTH-1:0] c1_wr_byte_valid,
  input  logic                        c1_rd_req,
  output logic                        c1_rd_gnt,
  input  logic [ADDR_WIDTH-1:0]       c1_rd_addr,
  output logic [DATA_WIDTH-1:0]       c1_rd_data,
  output logic                        c1_rd_data_valid,

  output logic                        ram_wr_en,
  output logic [DATA_WIDTH-1:0]       ram_wr_data,
  output logic [BYTE_VALID_WIDTH-1:0] ram_wr_byte_valid,
  output logic [ADDR_WIDTH-1:0]       ram_wr_addr,
  output logic                        ram_rd_en,
  output logic [ADDR_WIDTH-1:0]       ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]       ram_rd_data,
  input  logic                        ram_rd_data_valid
);

  localparam int RD_LAT = (IS_OUT_LATENCY == "true") ? 2 : 1;

  // Last client served on each port: 0 or 1. Reset to 1 so that client 0
  // wins the first contention.
  logic wr_last;
  logic rd_last;

  logic                        wr_acc;
  logic                        wr_sel;
  logic [ADDR_WIDTH-1:0]       wr_addr_mux;
  logic [DATA_WIDTH-1:0]       wr_data_mux;
  logic [BYTE_VALID_WIDTH-1:0] wr_bv_mux;

  logic                        c0_rd_elig;
  logic                        c1_rd_elig;
  logic                        rd_acc;
  logic                        rd_sel;
  logic [ADDR_WIDTH-1:0]       rd_addr_mux;

  logic [RD_LAT:0]             tag_valid;
  logic [RD_LAT:0]             tag_owner;

  // -------------------------------------------------------------------------
  // Write arbiter
  // -------------------------------------------------------------------------
  always_comb begin
    c0_wr_gnt = 1'b0;
    c1_wr_gnt = 1'b0;
    if (c0_wr_req && c1_wr_req) begin
      c0_wr_gnt = wr_last;
      c1_wr_gnt = !wr_last;
    end else begin
      c0_wr_gnt = c0_wr_req;
      c1_wr_gnt = c1_wr_req;
    end
  end

  assign wr_acc      = c0_wr_gnt | c1_wr_gnt;
  assign wr_sel      = c1_wr_gnt;
  assign wr_addr_mux = wr_sel ? c1_wr_addr       : c0_wr_addr;
  assign wr_data_mux = wr_sel ? c1_wr_data       : c0_wr_data;
  assign wr_bv_mux   = wr_sel ? c1_wr_byte_valid : c0_wr_byte_valid;

  // -------------------------------------------------------------------------
  // Read arbiter
  // A read that targets the address being written this cycle is masked out
  // before arbitration. It retries next cycle, after the write is already
  // ahead of it on the RAM pins, so it always sees the new data. Masking
  // before arbitration lets the other client's read through instead of
  // wasting the slot.
  // -------------------------------------------------------------------------
  assign c0_rd_elig = c0_rd_req && !(wr_acc && (wr_addr_mux == c0_rd_addr));
  assign c1_rd_elig = c1_rd_req && !(wr_acc && (wr_addr_mux == c1_rd_addr));

  always_comb begin
    c0_rd_gnt = 1'b0;
    c1_rd_gnt = 1'b0;
    if (c0_rd_elig && c1_rd_elig) begin
      c0_rd_gnt = rd_last;
      c1_rd_gnt = !rd_last;
    end else begin
      c0_rd_gnt = c0_rd_elig;
      c1_rd_gnt = c1_rd_elig;
    end
  end

  assign rd_acc      = c0_rd_gnt | c1_rd_gnt;
  assign rd_sel      = c1_rd_gnt;
  assign rd_addr_mux = rd_sel ? c1_rd_addr : c0_rd_addr;

  // -------------------------------------------------------------------------
  // Write issue register
  // The enable is a one-cycle pulse. Address, data and byte enables hold
  // their last values when idle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_last           <= 1'b1;
      ram_wr_en         <= 1'b0;
      ram_wr_addr       <= '0;
      ram_wr_data       <= '0;
      ram_wr_byte_valid <= '0;
    end else begin
      ram_wr_en <= wr_acc;
      if (wr_acc) begin
        wr_last           <= wr_sel;
        ram_wr_addr       <= wr_addr_mux;
        ram_wr_data       <= wr_data_mux;
        ram_wr_byte_valid <= wr_bv_mux;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read issue register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_last     <= 1'b1;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
    end else begin
      ram_rd_en <= rd_acc;
      if (rd_acc) begin
        rd_last     <= rd_sel;
        ram_rd_addr <= rd_addr_mux;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read tag pipeline
  // Stage 0 lines up with ram_rd_en. Stage RD_LAT lines up with the RAM
  // output. Clearing it on reset drops any read still in flight, so no
  // stale valid can reach a client.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= '0;
      tag_owner <= '0;
    end else begin
      tag_valid <= {tag_valid[RD_LAT-1:0], rd_acc};
      tag_owner <= {tag_owner[RD_LAT-1:0], rd_sel};
    end
  end

  // -------------------------------------------------------------------------
  // Return routing
  // Both tag valid and RAM valid are required. If the tag is valid but the
  // RAM data is not (a latency mismatch), neither client sees a valid.
  // -------------------------------------------------------------------------
  assign c0_rd_data       = ram_rd_data;
  assign c1_rd_data       = ram_rd_data;
  assign c0_rd_data_valid = tag_valid[RD_LAT] && !tag_owner[RD_LAT] && ram_rd_data_valid;
  assign c1_rd_data_valid = tag_valid[RD_LAT] &&  tag_owner[RD_LAT] && ram_rd_data_valid;

endmodule

// File: tb/tb_sdp_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdp_ram_arbiter
//
// Drives two arbiter instances with identical client stimulus: dut_a uses
// IS_OUT_LATENCY "false" and dut_b uses "true". Each instance has its own
// behavioural RAM with the matching read latency. The RAMs are deliberately
// not reset, so that in-flight data survives an arbiter reset.
// ---------------------------------------------------------------------------
module tb_sdp_ram_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic          c0_wr_req, c1_wr_req, c0_rd_req, c1_rd_req;
  logic [AW-1:0] c0_wr_addr, c1_wr_addr, c0_rd_addr, c1_rd_addr;
  logic [DW-1:0] c0_wr_data, c1_wr_data;
  logic [BW-1:0] c0_wr_bv, c1_wr_bv;

  // Signals for dut_a (read latency 1)
  logic          a_c0_wr_gnt, a_c1_wr_gnt, a_c0_rd_gnt, a_c1_rd_gnt;
  logic [DW-1:0] a_c0_rd_data, a_c1_rd_data;
  logic          a_c0_vld, a_c1_vld;
  logic          a_ram_wr_en, a_ram_rd_en;
  logic [DW-1:0] a_ram_wr_data;
  logic [BW-1:0] a_ram_wr_bv;
  logic [AW-1:0] a_ram_wr_addr, a_ram_rd_addr;
  logic [DW-1:0] a_ram_rd_data;
  logic          a_ram_rd_vld;

  // Signals for dut_b (read latency 2)
  logic          b_c0_wr_gnt, b_c1_wr_gnt, b_c0_rd_gnt, b_c1_rd_gnt;
  logic [DW-1:0] b_c0_rd_data, b_c1_rd_data;
  logic          b_c0_vld, b_c1_vld;
  logic          b_ram_wr_en, b_ram_rd_en;
  logic [DW-1:0] b_ram_wr_data;
  logic [BW-1:0] b_ram_wr_bv;
  logic [AW-1:0] b_ram_wr_addr, b_ram_rd_addr;
  logic [DW-1:0] b_ram_rd_data;
  logic          b_ram_rd_vld;

  sdp_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IS_OUT_LATENCY("false")) dut_a (
    .clk(clk), .rst_n(rst_n),
    .c0_wr_req(c0_wr_req), .c0_wr_gnt(a_c0_wr_gnt), .c0_wr_addr(c0_wr_addr),
    .c0_wr_data(c0_wr_data), .c0_wr_byte_valid(c0_wr_bv),
    .c0_rd_req(c0_rd_req), .c0_rd_gnt(a_c0_rd_gnt), .c0_rd_addr(c0_rd_addr),
    .c0_rd_data(a_c0_rd_data), .c0_rd_data_valid(a_c0_vld),
    .c1_wr_req(c1_wr_req), .c1_wr_gnt(a_c1_wr_gnt), .c1_wr_addr(c1_wr_addr),
    .c1_wr_data(c1_wr_data), .c1_wr_byte_valid(c1_wr_bv),
    .c1_rd_req(c1_rd_req), .c1_rd_gnt(a_c1_rd_gnt), .c1_rd_addr(c1_rd_addr),
    .c1_rd_data(a_c1_rd_data), .c1_rd_data_valid(a_c1_vld),
    .ram_wr_en(a_ram_wr_en), .ram_wr_data(a_ram_wr_data),
    .ram_wr_byte_valid(a_ram_wr_bv), .ram_wr_addr(a_ram_wr_addr),
    .ram_rd_en(a_ram_rd_en), .ram_rd_addr(a_ram_rd_addr),
    .ram_rd_data(a_ram_rd_data), .ram_rd_data_valid(a_ram_rd_vld)
  );

  sdp_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IS_OUT_LATENCY("true")) dut_b (
    .clk(clk), .rst_n(rst_n),
    .c0_wr_req(c0_wr_req), .c0_wr_gnt(b_c0_wr_gnt), .c0_wr_addr(c0_wr_addr),
    .c0_wr_data(c0_wr_data), .c0_wr_byte_valid(c0_wr_bv),
    .c0_rd_req(c0_rd_req), .c0_rd_gnt(b_c0_rd_gnt), .c0_rd_addr(c0_rd_addr),
    .c0_rd_data(b_c0_rd_data), .c0_rd_data_valid(b_c0_vld),
    .c1_wr_req(c1_wr_req), .c1_wr_gnt(b_c1_wr_gnt), .c1_wr_addr(c1_wr_addr),
    .c1_wr_data(c1_wr_data), .c1_wr_byte_valid(c1_wr_bv),
    .c1_rd_req(c1_rd_req), .c1_rd_gnt(b_c1_rd_gnt), .c1_rd_addr(c1_rd_addr),
    .c1_rd_data(b_c1_rd_data), .c1_rd_data_valid(b_c1_vld),
    .ram_wr_en(b_ram_wr_en), .ram_wr_data(b_ram_wr_data),
    .ram_wr_byte_valid(b_ram_wr_bv), .ram_wr_addr(b_ram_wr_addr),
    .ram_rd_en(b_ram_rd_en), .ram_rd_addr(b_ram_rd_addr),
    .ram_rd_data(b_ram_rd_data), .ram_rd_data_valid(b_ram_rd_vld)
  );

  // Behavioural RAM for dut_a, read latency 1, read-old-data on a same-edge
  // read/write.
  logic [DW-1:0] mem_a [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (a_ram_wr_en)
      for (int i = 0; i < BW; i++)
        if (a_ram_wr_bv[i]) mem_a[a_ram_wr_addr][8*i +: 8] <= a_ram_wr_data[8*i +: 8];
    a_ram_rd_data <= mem_a[a_ram_rd_addr];
    a_ram_rd_vld  <= a_ram_rd_en;
  end

  // Behavioural RAM for dut_b, read latency 2.
  logic [DW-1:0] mem_b [0:(1<<AW)-1];
  logic [DW-1:0] b_q1;
  logic          b_v1;
  always @(posedge clk) begin
    if (b_ram_wr_en)
      for (int i = 0; i < BW; i++)
        if (b_ram_wr_bv[i]) mem_b[b_ram_wr_addr][8*i +: 8] <= b_ram_wr_data[8*i +: 8];
    b_q1          <= mem_b[b_ram_rd_addr];
    b_v1          <= b_ram_rd_en;
    b_ram_rd_data <= b_q1;
    b_ram_rd_vld  <= b_v1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c0_wr_req = 1'b0; c1_wr_req = 1'b0; c0_rd_req = 1'b0; c1_rd_req = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    c0_wr_addr = '0; c1_wr_addr = '0; c0_rd_addr = '0; c1_rd_addr = '0;
    c0_wr_data = '0; c1_wr_data = '0; c0_wr_bv = '0; c1_wr_bv = '0;
    rst_n = 1'b0;
    cyc(); cyc();
    vectors++;
    if ({a_ram_wr_en, a_ram_rd_en, a_ram_wr_addr, a_ram_rd_addr, a_ram_wr_bv} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl got=%0h exp=0", {a_ram_wr_en, a_ram_rd_en, a_ram_wr_addr, a_ram_rd_addr, a_ram_wr_bv});
    end
    vectors++;
    if ({a_ram_wr_data, b_ram_wr_data} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data got=%0h exp=0", {a_ram_wr_data, b_ram_wr_data});
    end
    vectors++;
    if ({a_c0_vld, a_c1_vld, b_c0_vld, b_c1_vld} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_valid got=%b exp=0000", {a_c0_vld, a_c1_vld, b_c0_vld, b_c1_vld});
    end
    c0_wr_req = 1'b1; c0_wr_addr = 5'd9; c0_wr_data = 32'hCAFE_F00D; c0_wr_bv = 4'hF;
    #1;
    vectors++;
    if (a_c0_wr_gnt !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_gnt_comb got=%b exp=1", a_c0_wr_gnt);
    end
    cyc();
    vectors++;
    if ({a_ram_wr_en, a_ram_wr_addr} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_no_accept got=%0h exp=0", {a_ram_wr_en, a_ram_wr_addr});
    end
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_solo_write_read();
    cyc();
    c0_wr_req = 1'b1; c0_wr_addr = 5'd3; c0_wr_data = 32'hDEAD_BEEF; c0_wr_bv = 4'hF;
    #1;
    vectors++;
    if ({a_c0_wr_gnt, a_c1_wr_gnt} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL solo_wr_gnt got=%b exp=10", {a_c0_wr_gnt, a_c1_wr_gnt});
    end
    cyc();
    c0_wr_req = 1'b0;
    vectors++;
    if ({a_ram_wr_en, a_ram_wr_addr, a_ram_wr_data, a_ram_wr_bv} !== {1'b1, 5'd3, 32'hDEAD_BEEF, 4'hF}) begin
      miscompares++;
      $display("[TB] FAIL solo_wr_issue got=%0h exp=%0h", {a_ram_wr_en, a_ram_wr_addr, a_ram_wr_data, a_ram_wr_bv},
               {1'b1, 5'd3, 32'hDEAD_BEEF, 4'hF});
    end
    cyc();
    vectors++;
    if (a_ram_wr_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL solo_wr_pulse got=%b exp=0", a_ram_wr_en);
    end
    c0_rd_req = 1'b1; c0_rd_addr = 5'd3;
    #1;
    vectors++;
    if ({a_c0_rd_gnt, a_c1_rd_gnt} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL solo_rd_gnt got=%b exp=10", {a_c0_rd_gnt, a_c1_rd_gnt});
    end
    cyc();
    c0_rd_req = 1'b0;
    vectors++;
    if ({a_ram_rd_en, a_ram_rd_addr, a_c0_vld} !== {1'b1, 5'd3, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL solo_rd_issue got=%0h exp=%0h", {a_ram_rd_en, a_ram_rd_addr, a_c0_vld}, {1'b1, 5'd3, 1'b0});
    end
    cyc();
    vectors++;
    if ({a_c0_vld, a_c1_vld, a_c0_rd_data} !== {2'b10, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("[TB] FAIL solo_rd_return got=%0h exp=%0h", {a_c0_vld, a_c1_vld, a_c0_rd_data}, {2'b10, 32'hDEAD_BEEF});
    end
    vectors++;
    if (b_c0_vld !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL solo_lat2_early got=%b exp=0", b_c0_vld);
    end
    cyc();
    vectors++;
    if ({a_c0_vld, b_c0_vld, b_c1_vld, b_c0_rd_data} !== {3'b010, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("[TB] FAIL solo_lat2_return got=%0h exp=%0h", {a_c0_vld, b_c0_vld, b_c1_vld, b_c0_rd_data},
               {3'b010, 32'hDEAD_BEEF});
    end
  endtask

  task automatic test_write_contention();
    logic [AW-1:0] exp_addr;
    logic          exp_c0;
    do_reset();
    c0_wr_req = 1'b1; c0_wr_addr = 5'd1; c0_wr_data = 32'h1111_0001; c0_wr_bv = 4'hF;
    c1_wr_req = 1'b1; c1_wr_addr = 5'd2; c1_wr_data = 32'h2222_0002; c1_wr_bv = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_c0   = (i % 2 == 0);
      exp_addr = exp_c0 ? 5'd1 : 5'd2;
      vectors++;
      if ({a_c0_wr_gnt, a_c1_wr_gnt} !== {exp_c0, !exp_c0}) begin
        miscompares++;
        $display("[TB] FAIL contention_gnt[%0d] got=%b exp=%b", i, {a_c0_wr_gnt, a_c1_wr_gnt}, {exp_c0, !exp_c0});
      end
      cyc();
      if (i == 3) idle();
      vectors++;
      if ({a_ram_wr_en, a_ram_wr_addr} !== {1'b1, exp_addr}) begin
        miscompares++;
        $display("[TB] FAIL contention_addr[%0d] got=%0h exp=%0h", i, {a_ram_wr_en, a_ram_wr_addr}, {1'b1, exp_addr});
      end
    end
    cyc();
    vectors++;
    if ({a_ram_wr_en, a_ram_wr_addr} !== {1'b0, 5'd2}) begin
      miscompares++;
      $display("[TB] FAIL contention_hold got=%0h exp=%0h", {a_ram_wr_en, a_ram_wr_addr}, {1'b0, 5'd2});
    end
  endtask

  task automatic test_read_routing();
    c0_wr_req = 1'b1; c0_wr_addr = 5'd0; c0_wr_data = 32'h0000_0011; c0_wr_bv = 4'hF;
    c1_wr_req = 1'b1; c1_wr_addr = 5'd1; c1_wr_data = 32'h0000_0022; c1_wr_bv = 4'hF;
    cyc();
    c0_wr_req = 1'b0;
    cyc();
    idle();
    cyc();
    c0_rd_req = 1'b1; c0_rd_addr = 5'd0;
    c1_rd_req = 1'b1; c1_rd_addr = 5'd1;
    #1;
    vectors++;
    if ({a_c0_rd_gnt, a_c1_rd_gnt} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL route_gnt0 got=%b exp=10", {a_c0_rd_gnt, a_c1_rd_gnt});
    end
    cyc();
    c0_rd_req = 1'b0;
    #1;
    vectors++;
    if ({a_c0_rd_gnt, a_c1_rd_gnt, a_ram_rd_en, a_ram_rd_addr} !== {3'b011, 5'd0}) begin
      miscompares++;
      $display("[TB] FAIL route_gnt1 got=%0h exp=%0h", {a_c0_rd_gnt, a_c1_rd_gnt, a_ram_rd_en, a_ram_rd_addr}, {3'b011, 5'd0});
    end
    cyc();
    c1_rd_req = 1'b0;
    vectors++;
    if ({a_c0_vld, a_c1_vld, a_c0_rd_data, a_ram_rd_addr} !== {2'b10, 32'h0000_0011, 5'd1}) begin
      miscompares++;
      $display("[TB] FAIL route_c0 got=%0h exp=%0h", {a_c0_vld, a_c1_vld, a_c0_rd_data, a_ram_rd_addr},
               {2'b10, 32'h0000_0011, 5'd1});
    end
    cyc();
    vectors++;
    if ({a_c0_vld, a_c1_vld, a_c1_rd_data} !== {2'b01, 32'h0000_0022}) begin
      miscompares++;
      $display("[TB] FAIL route_c1 got=%0h exp=%0h", {a_c0_vld, a_c1_vld, a_c1_rd_data}, {2'b01, 32'h0000_0022});
    end
  endtask

  task automatic test_collision();
    cyc();
    c0_wr_req = 1'b1; c0_wr_addr = 5'd5; c0_wr_data = 32'hA5A5_A5A5; c0_wr_bv = 4'hF;
    c1_rd_req = 1'b1; c1_rd_addr = 5'd5;
    #1;
    vectors++;
    if ({a_c0_wr_gnt, a_c1_rd_gnt} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL collision_stall got=%b exp=10", {a_c0_wr_gnt, a_c1_rd_gnt});
    end
    cyc();
    c0_wr_req = 1'b0;
    #1;
    vectors++;
    if (a_c1_rd_gnt !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL collision_retry got=%b exp=1", a_c1_rd_gnt);
    end
    cyc();
    c1_rd_req = 1'b0;
    cyc();
    vectors++;
    if ({a_c0_vld, a_c1_vld, a_c1_rd_data} !== {2'b01, 32'hA5A5_A5A5}) begin
      miscompares++;
      $display("[TB] FAIL collision_data got=%0h exp=%0h", {a_c0_vld, a_c1_vld, a_c1_rd_data}, {2'b01, 32'hA5A5_A5A5});
    end
  endtask

  task automatic test_byte_mask();
    cyc();
    c0_wr_req = 1'b1; c0_wr_addr = 5'd7; c0_wr_data = 32'hFFFF_FFFF; c0_wr_bv = 4'hF;
    cyc();
    c0_wr_data = 32'h1234_5678; c0_wr_bv = 4'h5;
    cyc();
    vectors++;
    if ({a_ram_wr_data, a_ram_wr_bv} !== {32'h1234_5678, 4'h5}) begin
      miscompares++;
      $display("[TB] FAIL mask_issue got=%0h exp=%0h", {a_ram_wr_data, a_ram_wr_bv}, {32'h1234_5678, 4'h5});
    end
    c0_wr_data = 32'h0000_0000; c0_wr_bv = 4'h0;
    cyc();
    c0_wr_req = 1'b0;
    vectors++;
    if ({a_ram_wr_en, a_ram_wr_bv} !== {1'b1, 4'h0}) begin
      miscompares++;
      $display("[TB] FAIL mask_zero_issue got=%0h exp=%0h", {a_ram_wr_en, a_ram_wr_bv}, {1'b1, 4'h0});
    end
    cyc();
    c0_rd_req = 1'b1; c0_rd_addr = 5'd7;
    cyc();
    c0_rd_req = 1'b0;
    cyc();
    vectors++;
    if ({a_c0_vld, a_c0_rd_data} !== {1'b1, 32'hFF34_FF78}) begin
      miscompares++;
      $display("[TB] FAIL mask_data got=%0h exp=%0h", {a_c0_vld, a_c0_rd_data}, {1'b1, 32'hFF34_FF78});
    end
  endtask

  task automatic test_reset_mid_read();
    logic seen_client;
    logic seen_ram;
    seen_client = 1'b0;
    seen_ram    = 1'b0;
    cyc();
    c0_rd_req = 1'b1; c0_rd_addr = 5'd3;
    cyc();
    c0_rd_req = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({b_ram_rd_en, b_ram_rd_addr, b_ram_wr_addr} !== '0) begin
      miscompares++;
      $display("[TB] FAIL midrd_async got=%0h exp=0", {b_ram_rd_en, b_ram_rd_addr, b_ram_wr_addr});
    end
    for (int t = 0; t < 70; t++) begin
      if (t == 25) rst_n = 1'b1;
      if (b_c0_vld || b_c1_vld) seen_client = 1'b1;
      if (b_ram_rd_vld) seen_ram = 1'b1;
      #1;
    end
    vectors++;
    if (seen_client !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrd_stale_valid got=%b exp=0", seen_client);
    end
    vectors++;
    if (seen_ram !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midrd_ram_inflight got=%b exp=1", seen_ram);
    end
    cyc();
    c0_wr_req = 1'b1; c0_wr_addr = 5'd10; c0_wr_data = 32'h0A0A_0A0A; c0_wr_bv = 4'hF;
    c1_wr_req = 1'b1; c1_wr_addr = 5'd11; c1_wr_data = 32'h0B0B_0B0B; c1_wr_bv = 4'hF;
    c0_rd_req = 1'b1; c0_rd_addr = 5'd12;
    c1_rd_req = 1'b1; c1_rd_addr = 5'd13;
    #1;
    vectors++;
    if ({b_c0_wr_gnt, b_c1_wr_gnt, b_c0_rd_gnt, b_c1_rd_gnt} !== 4'b1010) begin
      miscompares++;
      $display("[TB] FAIL midrd_first_contention got=%b exp=1010", {b_c0_wr_gnt, b_c1_wr_gnt, b_c0_rd_gnt, b_c1_rd_gnt});
    end
    cyc();
    idle();
    vectors++;
    if ({b_ram_wr_addr, b_ram_rd_addr} !== {5'd10, 5'd12}) begin
      miscompares++;
      $display("[TB] FAIL midrd_issue got=%0h exp=%0h", {b_ram_wr_addr, b_ram_rd_addr}, {5'd10, 5'd12});
    end
    cyc(); cyc(); cyc();
  endtask

  initial begin
    $display("[TB] starting sdp_ram_arbiter bench");
    test_reset();
    test_solo_write_read();
    test_write_contention();
    test_read_routing();
    test_collision();
    test_byte_mask();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
